// File: rtl/array_stream_ctrl_pkg.sv
// Shared definitions for the array compute/readout sequencer: FSM states,
// default parameter values and pointer-width helper.
package array_stream_ctrl_pkg;

    localparam int DEF_W              = 32;
    localparam int DEF_PACKETS        = 8;
    localparam int DEF_COMPUTE_CYCLES = 16;
    localparam int DEF_LOAD_CYCLES    = 2;
    localparam int DEF_TIMEOUT        = 64;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_LOAD,
        S_WAIT_V,
        S_CAPTURE,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    // Pointers carry one extra bit so "full" (== packets) is representable.
    function automatic int ptr_w(input int packets);
        return $clog2(packets) + 1;
    endfunction

endpackage

// File: rtl/array_stream_ctrl_if.sv
// Downstream valid/ready stream carrying buffered serializer packets.
interface array_stream_ctrl_if import array_stream_ctrl_pkg::*; #(
    parameter int W = DEF_W
);
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/array_stream_ctrl_pkt_buffer.sv
// PACKETS x W register file with one write port, one asynchronous read port
// and non-wrapping write/read pointers.
module pkt_buffer import array_stream_ctrl_pkg::*; #(
    parameter int W       = DEF_W,
    parameter int PACKETS = DEF_PACKETS,
    localparam int PW     = ptr_w(PACKETS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr
);
    localparam int AW = (PACKETS > 1) ? $clog2(PACKETS) : 1;

    logic [W-1:0] mem [PACKETS];

    // Payload storage; contents are only meaningful below wr_ptr, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers restart at zero for every transaction and never wrap within one.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/array_stream_ctrl.sv
// Sequences one array compute + serializer readout: clear, compute, load,
// capture the non-stallable serializer stream into a local buffer and drain
// it downstream over valid/ready, finishing with done or a sticky timeout.
module array_stream_ctrl import array_stream_ctrl_pkg::*; #(
    parameter int W              = DEF_W,
    parameter int PACKETS        = DEF_PACKETS,
    parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES,
    parameter int LOAD_CYCLES    = DEF_LOAD_CYCLES,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                array_en,
    output logic                ser_clear,
    output logic                load_data,
    input  logic [W-1:0]        ser_data,
    input  logic                ser_valid,
    array_stream_ctrl_if.master m
);
    localparam int PW      = ptr_w(PACKETS);
    localparam int CNT_MAX = (COMPUTE_CYCLES > LOAD_CYCLES)
                           ? ((COMPUTE_CYCLES > TIMEOUT) ? COMPUTE_CYCLES : TIMEOUT)
                           : ((LOAD_CYCLES > TIMEOUT) ? LOAD_CYCLES : TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  rd_data;
    logic          wr_en;
    logic          rd_en;
    logic          clr;
    logic          m_valid;
    logic          wr_last;

    // A beat is stored on its first arrival in WAIT_V and then until the buffer
    // holds PACKETS beats; anything else from the serializer is dropped.
    assign wr_en   = ser_valid && ((state == S_WAIT_V) ||
                     ((state == S_CAPTURE) && (wr_ptr < PW'(PACKETS))));
    assign wr_last = (wr_ptr == PW'(PACKETS - 1));
    assign clr     = ((state == S_IDLE) && start) || (state == S_ERROR);

    assign m_valid   = (rd_ptr < wr_ptr);
    assign rd_en     = m_valid && m.m_ready;
    assign m.m_valid = m_valid;
    assign m.m_data  = m_valid ? rd_data : '0;
    assign m.m_last  = m_valid && (rd_ptr == PW'(PACKETS - 1));
    assign busy      = (state != S_IDLE);

    pkt_buffer #(
        .W       (W),
        .PACKETS (PACKETS)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data (ser_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    // Transaction FSM with registered strobes, shared phase/timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ser_clear <= 1'b0;
            array_en  <= 1'b0;
            load_data <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        ser_clear <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    ser_clear <= 1'b0;
                    array_en  <= 1'b1;
                    cnt       <= '0;
                    state     <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (cnt == CW'(COMPUTE_CYCLES - 1)) begin
                        cnt       <= '0;
                        load_data <= 1'b1;
                        state     <= S_LOAD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LOAD: begin
                    if (cnt == CW'(LOAD_CYCLES - 1)) begin
                        cnt       <= '0;
                        load_data <= 1'b0;
                        array_en  <= 1'b0;
                        state     <= S_WAIT_V;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_V: begin
                    if (ser_valid) begin
                        state <= wr_last ? S_DRAIN : S_CAPTURE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state <= S_ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (ser_valid && wr_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Finish on the cycle the last beat is accepted, or once it has been.
                    if ((rd_ptr == PW'(PACKETS)) ||
                        (rd_en && (rd_ptr == PW'(PACKETS - 1)))) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    err   <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_stream_ctrl.sv
// Scoreboard bench for array_stream_ctrl: directed transactions push expected
// beats, a negedge monitor pops and compares whatever the DUT delivers.
module tb_array_stream_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic         array_en;
    logic         ser_clear;
    logic         load_data;
    logic [W-1:0] ser_data;
    logic         ser_valid;

    array_stream_ctrl_if #(.W(W)) bus();

    array_stream_ctrl #(
        .W              (W),
        .PACKETS        (8),
        .COMPUTE_CYCLES (16),
        .LOAD_CYCLES    (2),
        .TIMEOUT        (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .array_en  (array_en),
        .ser_clear (ser_clear),
        .load_data (load_data),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .m         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks     = 0;
    int    n_fail       = 0;
    int    cyc          = 0;
    int    done_cnt     = 0;
    int    last_acc_cyc = -10;
    bit    bp_mode      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready: constantly 1, or toggling each cycle in backpressure mode.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = bp_mode ? ~bus.m_ready : 1'b1;
        end
    end

    // Monitor: compare accepted beats against the queue, hold-while-stalled, done timing.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_data;
        beat_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_hold", 64'(bus.m_valid), 64'(1));
                    chk("stall_data_hold", 64'(bus.m_data), 64'(prev_data));
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h, expected no beat (cycle %0d)",
                                 bus.m_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", 64'(bus.m_data), 64'(e.data));
                        chk("m_last", 64'(bus.m_last), 64'(e.last));
                    end
                    if (bus.m_last) last_acc_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_last_beat", 64'(cyc), 64'(last_acc_cyc + 1));
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
            end
        end
    end

    // Abort if the run ever stops making progress.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: ran %0d cycles, expected completion before 20000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic push_beats(input int first);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{data: W'(first + i), last: 1'(i == 7)});
        end
    endtask

    // Start pulse, then check the clear/compute/load strobe sequence cycle by cycle.
    task automatic start_and_check(input bit dup);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("clear_phase", 64'({busy, ser_clear, array_en, load_data, err}), 64'(5'b11000));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (dup && i == 4) start = 1'b1;
            if (dup && i == 5) start = 1'b0;
            chk("compute_phase", 64'({ser_clear, array_en, load_data}), 64'(3'b010));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("load_phase", 64'({ser_clear, array_en, load_data}), 64'(3'b011));
        end
        @(negedge clk);
        chk("wait_phase", 64'({busy, ser_clear, array_en, load_data}), 64'(4'b1000));
    endtask

    task automatic send_beats(input int n, input int first, input int gap_after);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ser_valid = 1'b1;
            ser_data  = W'(first + i);
            if (i == gap_after) begin
                @(posedge clk); #1;
                ser_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        ser_valid = 1'b0;
        ser_data  = '0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("done_count", 64'(done_cnt), 64'(target));
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        chk("idle_after_done", 64'({busy, bus.m_valid, err}), 64'(0));
    endtask

    task automatic nominal(input int first, input int target, input int gap_after);
        push_beats(first);
        start_and_check(1'b0);
        send_beats(8, first, gap_after);
        wait_done(target);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, err, array_en, ser_clear, load_data}), 64'(0));
        chk("reset_stream", 64'({bus.m_valid, bus.m_last, bus.m_data}), 64'(0));
        @(posedge clk); #1; reset = 1'b0;

        // 1: nominal run, beats 1..8 with m_ready high
        nominal(1, 1, -1);

        // 2: backpressure, ready toggling while beats arrive back-to-back
        bp_mode = 1'b1;
        nominal(32'h100, 2, -1);
        bp_mode = 1'b0;

        // 3: timeout with no serializer response, then a recovery run
        begin
            int n = 0;
            start_and_check(1'b0);
            while (!err && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency_64_65", 64'(n >= 64 && n <= 65), 64'(1));
            chk("timeout_busy_low", 64'(busy), 64'(0));
            chk("timeout_no_done", 64'(done_cnt), 64'(2));
            repeat (5) @(negedge clk);
            chk("err_sticky", 64'(err), 64'(1));
        end
        nominal(1, 3, -1);

        // 4: serializer chatter in IDLE and a 9th beat after the 8th
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ser_valid = 1'b1;
            ser_data  = 32'hDEAD_0000 + W'(i);
            @(negedge clk);
            chk("idle_beat_ignored", 64'({busy, bus.m_valid}), 64'(0));
        end
        @(posedge clk); #1; ser_valid = 1'b0;
        push_beats(1);
        start_and_check(1'b0);
        send_beats(9, 1, -1);
        wait_done(4);

        // 5: second start during COMPUTE is dropped
        push_beats(32'h55);
        start_and_check(1'b1);
        send_beats(8, 32'h55, -1);
        wait_done(5);
        repeat (40) @(posedge clk);
        #1;
        chk("dup_start_single_done", 64'(done_cnt), 64'(5));
        chk("dup_start_no_rerun", 64'(busy), 64'(0));

        // 6: reset in CAPTURE after beat 4, then a fresh run with a ser_valid gap
        push_beats(32'h70);
        start_and_check(1'b0);
        send_beats(4, 32'h70, -1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_ctrl", 64'({busy, done, err, array_en, ser_clear, load_data}), 64'(0));
        chk("midreset_stream", 64'({bus.m_valid, bus.m_last, bus.m_data}), 64'(0));
        exp_q.delete();
        @(posedge clk); #1; reset = 1'b0;
        chk("midreset_no_done", 64'(done_cnt), 64'(5));
        nominal(32'h90, 6, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
